// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: FSM state encodings,
// status counter widths and the lock-loss saturation value.
package pll_seq_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 2;
    localparam int unsigned LOSS_W  = 8;

    localparam logic [LOSS_W-1:0] LOSS_SAT = LOSS_W'(255);

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

endpackage

// File: rtl/bit_sync_2ff.sv
// Single-bit synchronizer chain with async active-low reset (reset value 0).
// Ports:
//   clk    - destination domain clock
//   rst_n  - asynchronous active-low reset
//   d      - asynchronous input bit
//   q      - synchronized output, STAGES cycles of latency
module bit_sync_2ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift register; only the last stage is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for lock with a timeout
// and bounded retries, qualifies lock as stable and then releases the
// downstream system reset. Lock loss while running restarts the sequence.
// Ports:
//   refclk          - 50 MHz reference clock (sole clock)
//   rst_n           - asynchronous active-low reset
//   pll_locked      - raw PLL lock, asynchronous to refclk
//   soft_reset_req  - single-cycle sequence restart request
//   pll_rst         - active-high PLL reset
//   sys_rst_n       - active-low downstream reset release
//   ready           - locked, stable and released
//   fault           - retries exhausted
//   retry_cnt       - failed attempts in the current sequence
//   lock_loss_cnt   - saturating count of lock losses while running
//   state_o         - current FSM state encoding
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = 10,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned LOCK_STABLE_CYC  = 256,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned CNT_W            = 16
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               soft_reset_req,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  lock_loss_cnt,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [LOSS_W-1:0]  loss_nxt;
    logic               pll_rst_nxt;
    logic               run_nxt;
    logic               fault_nxt;
    logic               locked_s;

    // Lock indicator crosses into refclk; only locked_s is used below.
    bit_sync_2ff #(
        .STAGES (2)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // State, counters and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_PLL_RST;
            cnt           <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            pll_rst       <= pll_rst_nxt;
            sys_rst_n     <= run_nxt;
            ready         <= run_nxt;
            fault         <= fault_nxt;
        end
    end

    assign state_o = state;

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        retry_nxt   = retry_cnt;
        loss_nxt    = lock_loss_cnt;
        pll_rst_nxt = 1'b1;
        run_nxt     = 1'b0;
        fault_nxt   = 1'b0;

        case (state)
            ST_PLL_RST: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock wins over a timeout landing on the same cycle.
                if (locked_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt = '0;
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        state_nxt = ST_PLL_RST;
                        retry_nxt = retry_cnt + RETRY_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Counted even if a soft reset lands on the same cycle.
                if (!locked_s) begin
                    state_nxt = ST_PLL_RST;
                    cnt_nxt   = '0;
                    if (lock_loss_cnt != LOSS_SAT) begin
                        loss_nxt = lock_loss_cnt + LOSS_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_PLL_RST;
                cnt_nxt   = '0;
            end
        endcase

        if (soft_reset_req) begin
            state_nxt = ST_PLL_RST;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end

        if (state_nxt == ST_RUN) begin
            retry_nxt = '0;
        end

        // Outputs follow the state being entered so they change on the
        // same edge as the transition.
        pll_rst_nxt = (state_nxt == ST_PLL_RST) || (state_nxt == ST_FAULT);
        run_nxt     = (state_nxt == ST_RUN);
        fault_nxt   = (state_nxt == ST_FAULT);
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

    localparam int unsigned RST_PULSE_CYC    = 4;
    localparam int unsigned LOCK_TIMEOUT_CYC = 20;
    localparam int unsigned LOCK_STABLE_CYC  = 8;
    localparam int unsigned MAX_RETRIES      = 2;
    localparam int unsigned CNT_W            = 16;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_q[$];

    pll_lock_sequencer #(
        .RST_PULSE_CYC    (RST_PULSE_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .MAX_RETRIES      (MAX_RETRIES),
        .CNT_W            (CNT_W)
    ) dut (
        .refclk         (refclk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .sys_rst_n      (sys_rst_n),
        .ready          (ready),
        .fault          (fault),
        .retry_cnt      (retry_cnt),
        .lock_loss_cnt  (lock_loss_cnt),
        .state_o        (state_o)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    // Cycle at which ready is expected: lock must pass the synchronizer and
    // the FSM must be in WAIT_LOCK, then one cycle to enter STABLE and the
    // qualification window.
    function automatic int exp_ready(input int rise, input int wait_entry);
        int seen;
        seen = rise + 2;
        if (wait_entry > seen) seen = wait_entry;
        return seen + 1 + int'(LOCK_STABLE_CYC);
    endfunction

    // Wait until a selected output equals a value; at = -1 on expired budget.
    task automatic wait_sig(input int sel, input int val, input int budget, output int at);
        int v;
        at = -1;
        for (int i = 0; i <= budget; i++) begin
            case (sel)
                0:       v = int'(ready);
                1:       v = int'(pll_rst);
                2:       v = int'(fault);
                default: v = int'(state_o);
            endcase
            if (v == val) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        rst_n          = 1'b0;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        repeat (3) tick();
        obs = {pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt, state_o};
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3'd0}) begin
            n_err++;
            $display("FAIL reset_values: got %h expected %h", obs,
                     {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3'd0});
        end
        pll_locked = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (state_o !== 3'd0 || pll_rst !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold: state %0d pll_rst %b expected 0 / 1", state_o, pll_rst);
        end
        pll_locked = 1'b0;
    endtask

    task automatic test_bring_up();
        int t;
        int t2;
        int rise;
        apply_reset();
        exp_q.push_back(int'(RST_PULSE_CYC));
        wait_sig(1, 0, 20, t);
        n_cmp++;
        if (t != exp_q[0]) begin
            n_err++;
            $display("FAIL bringup_pll_rst_width: got %0d expected %0d", t, exp_q[0]);
        end
        void'(exp_q.pop_front());
        repeat (5) tick();
        pll_locked = 1'b1;
        rise = cyc;
        exp_q.push_back(exp_ready(rise, t));
        wait_sig(0, 1, 60, t2);
        n_cmp++;
        if (t2 != exp_q[0] || t2 - rise != 11) begin
            n_err++;
            $display("FAIL bringup_ready_cycle: got %0d expected %0d (lock rose %0d)", t2, exp_q[0], rise);
        end
        void'(exp_q.pop_front());
        n_cmp++;
        if ({sys_rst_n, pll_rst, retry_cnt, state_o} !== {1'b1, 1'b0, 2'd0, 3'd3}) begin
            n_err++;
            $display("FAIL bringup_outputs: sys_rst_n %b pll_rst %b retry %0d state %0d expected 1 0 0 3",
                     sys_rst_n, pll_rst, retry_cnt, state_o);
        end
    endtask

    task automatic test_lock_loss();
        int c;
        int t;
        int t2;
        int rise;
        c = cyc;
        pll_locked = 1'b0;
        exp_q.push_back(c + 3);
        wait_sig(0, 0, 10, t);
        n_cmp++;
        if (t != exp_q[0]) begin
            n_err++;
            $display("FAIL lockloss_ready_drop: got %0d expected %0d", t, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_cmp++;
        if ({sys_rst_n, pll_rst, lock_loss_cnt, state_o} !== {1'b0, 1'b1, 8'd1, 3'd0}) begin
            n_err++;
            $display("FAIL lockloss_outputs: sys_rst_n %b pll_rst %b loss %0d state %0d expected 0 1 1 0",
                     sys_rst_n, pll_rst, lock_loss_cnt, state_o);
        end
        pll_locked = 1'b1;
        rise = cyc;
        exp_q.push_back(cyc + int'(RST_PULSE_CYC));
        wait_sig(1, 0, 20, t);
        n_cmp++;
        if (t != exp_q[0]) begin
            n_err++;
            $display("FAIL lockloss_pll_rst_fall: got %0d expected %0d", t, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(exp_ready(rise, t));
        wait_sig(0, 1, 60, t2);
        n_cmp++;
        if (t2 != exp_q[0] || sys_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL lockloss_relock_ready: got %0d sys_rst_n %b expected %0d 1", t2, sys_rst_n, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_glitch();
        int t;
        int at;
        int rise;
        bit saw_stable;
        bit saw_back;
        apply_reset();
        wait_sig(1, 0, 20, t);
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (4) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        rise = cyc;
        exp_q.push_back(exp_ready(rise, t));
        at = -1;
        saw_stable = 1'b0;
        saw_back = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (state_o == 3'd2) saw_stable = 1'b1;
            if (saw_stable && state_o == 3'd1) saw_back = 1'b1;
            if (ready === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        n_cmp++;
        if (saw_back !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_return_wait_lock: got %b expected 1", saw_back);
        end
        n_cmp++;
        if (at != exp_q[0] || at - rise != 11) begin
            n_err++;
            $display("FAIL glitch_ready_cycle: got %0d expected %0d", at, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_timeout_fault();
        int wq[$];
        int width;
        int at;
        apply_reset();
        exp_q.push_back(int'((MAX_RETRIES + 1) * (RST_PULSE_CYC + LOCK_TIMEOUT_CYC)));
        width = 0;
        at = -1;
        for (int i = 0; i < 120; i++) begin
            if (fault === 1'b1) begin
                at = cyc;
                break;
            end
            if (pll_rst === 1'b1) begin
                width++;
            end else if (width > 0) begin
                wq.push_back(width);
                width = 0;
            end
            tick();
        end
        n_cmp++;
        if (at != exp_q[0]) begin
            n_err++;
            $display("FAIL timeout_fault_cycle: got %0d expected %0d", at, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_cmp++;
        if (wq.size() != 3) begin
            n_err++;
            $display("FAIL timeout_pulse_count: got %0d expected 3", wq.size());
        end
        foreach (wq[i]) begin
            n_cmp++;
            if (wq[i] != int'(RST_PULSE_CYC)) begin
                n_err++;
                $display("FAIL timeout_pulse_width[%0d]: got %0d expected %0d", i, wq[i], RST_PULSE_CYC);
            end
        end
        n_cmp++;
        if ({retry_cnt, pll_rst, sys_rst_n, ready, state_o} !== {2'd2, 1'b1, 1'b0, 1'b0, 3'd4}) begin
            n_err++;
            $display("FAIL fault_outputs: retry %0d pll_rst %b sys_rst_n %b ready %b state %0d expected 2 1 0 0 4",
                     retry_cnt, pll_rst, sys_rst_n, ready, state_o);
        end
        pll_locked = 1'b1;
        repeat (30) tick();
        n_cmp++;
        if (fault !== 1'b1 || state_o !== 3'd4) begin
            n_err++;
            $display("FAIL fault_sticky: fault %b state %0d expected 1 4", fault, state_o);
        end
        pll_locked = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_fault_recovery();
        int t;
        int t2;
        int rise;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        n_cmp++;
        if ({fault, retry_cnt, pll_rst, state_o} !== {1'b0, 2'd0, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL recover_outputs: fault %b retry %0d pll_rst %b state %0d expected 0 0 1 0",
                     fault, retry_cnt, pll_rst, state_o);
        end
        exp_q.push_back(cyc + int'(RST_PULSE_CYC));
        wait_sig(1, 0, 20, t);
        n_cmp++;
        if (t != exp_q[0]) begin
            n_err++;
            $display("FAIL recover_pll_rst_fall: got %0d expected %0d", t, exp_q[0]);
        end
        void'(exp_q.pop_front());
        pll_locked = 1'b1;
        rise = cyc;
        exp_q.push_back(exp_ready(rise, t));
        wait_sig(0, 1, 60, t2);
        n_cmp++;
        if (t2 != exp_q[0]) begin
            n_err++;
            $display("FAIL recover_ready_cycle: got %0d expected %0d", t2, exp_q[0]);
        end
        void'(exp_q.pop_front());
        // Lock loss reaches the FSM on the same edge as a soft reset.
        pll_locked = 1'b0;
        tick();
        tick();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        n_cmp++;
        if ({state_o, ready, sys_rst_n, lock_loss_cnt} !== {3'd0, 1'b0, 1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL coincident_soft_loss: state %0d ready %b sys_rst_n %b loss %0d expected 0 0 0 1",
                     state_o, ready, sys_rst_n, lock_loss_cnt);
        end
    endtask

    task automatic test_saturation();
        int t;
        int exp_loss;
        logic [16:0] obs;
        apply_reset();
        wait_sig(1, 0, 20, t);
        pll_locked = 1'b1;
        wait_sig(0, 1, 60, t);
        exp_loss = 0;
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
            exp_q.push_back(exp_loss);
            wait_sig(0, 0, 10, t);
            n_cmp++;
            if (t < 0 || int'(lock_loss_cnt) != exp_q[0]) begin
                n_err++;
                $display("FAIL sat_loss_cnt[%0d]: got %0d expected %0d (drop seen %0d)",
                         i, lock_loss_cnt, exp_q[0], t);
            end
            void'(exp_q.pop_front());
            pll_locked = 1'b1;
            wait_sig(0, 1, 40, t);
            if (t < 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sat_relock_timeout[%0d]: ready %b expected 1", i, ready);
                break;
            end
        end
        n_cmp++;
        if (lock_loss_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL sat_final: got %0d expected 255", lock_loss_cnt);
        end
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        n_cmp++;
        if (lock_loss_cnt !== 8'd255 || state_o !== 3'd0) begin
            n_err++;
            $display("FAIL soft_keeps_loss: loss %0d state %0d expected 255 0", lock_loss_cnt, state_o);
        end
        wait_sig(3, 2, 30, t);
        tick();
        tick();
        n_cmp++;
        if (state_o !== 3'd2) begin
            n_err++;
            $display("FAIL midstable_state: got %0d expected 2", state_o);
        end
        rst_n = 1'b0;
        #1;
        obs = {pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt, state_o};
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3'd0}) begin
            n_err++;
            $display("FAIL async_reset_midstable: got %h expected %h", obs,
                     {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3'd0});
        end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_lock_loss();
        test_glitch();
        test_timeout_fault();
        test_fault_recovery();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls PLL reset and bring-up for a PLL running from the 50 MHz reference clock.
- Pulses the PLL reset and waits for lock, with a timeout and a bounded number of retries.
- Qualifies lock as stable before releasing the downstream system reset.
- On loss of lock: counts the event, re-asserts the system reset and re-runs the sequence. Sits between the board reset and the PLL, plus every block clocked by the PLL.

Parameters:
- RST_PULSE_CYC, 10: refclk cycles the PLL reset is held high per attempt (min 1).
- LOCK_TIMEOUT_CYC, 50000: refclk cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- LOCK_STABLE_CYC, 256: consecutive synchronized-lock-high cycles required before release.
- MAX_RETRIES, 3: re-attempts after the first timeout before declaring fault.
- CNT_W, 16: width of the shared cycle counter; must hold max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC).

Ports:
- refclk  in  1  sole clock, 50 MHz reference
- rst_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  raw PLL lock indicator, asynchronous to refclk
- soft_reset_req  in  1  single-cycle request to restart the sequence
- pll_rst  out  1  active-high reset to the PLL
- sys_rst_n  out  1  active-low release for downstream logic; re-synchronized in each consumer domain
- ready  out  1  PLL locked, stable and released
- fault  out  1  retries exhausted
- retry_cnt  out  2  failed attempts in the current sequence
- lock_loss_cnt  out  8  saturating count of lock losses while in RUN
- state_o  out  3  current FSM state encoding

Behaviour:
- One clock (refclk). Asynchronous active-low reset (rst_n). All outputs are registered.
- Reset values:
  - pll_rst=1, sys_rst_n=0, ready=0, fault=0
  - retry_cnt=0, lock_loss_cnt=0
  - state=PLL_RST, counter=0
- Lock synchronizer: pll_locked passes through a 2-flop synchronizer to give locked_s (2-cycle latency). Only locked_s is used.
- State PLL_RST (0):
  - pll_rst=1, sys_rst_n=0, ready=0.
  - counter increments each cycle.
  - At counter==RST_PULSE_CYC-1, go to WAIT_LOCK with counter=0. pll_rst is therefore high exactly RST_PULSE_CYC cycles.
- State WAIT_LOCK (1):
  - pll_rst=0.
  - If locked_s=1, go to STABLE with counter=0.
  - Else, at counter==LOCK_TIMEOUT_CYC-1:
    - if retry_cnt==MAX_RETRIES, go to FAULT;
    - otherwise retry_cnt+1 and go to PLL_RST.
- State STABLE (2):
  - counter increments while locked_s=1.
  - If locked_s=0, go to WAIT_LOCK with counter=0. Timeout restarts; retry_cnt is unchanged.
  - At counter==LOCK_STABLE_CYC-1 with locked_s=1, go to RUN.
- State RUN (3):
  - sys_rst_n=1, ready=1, retry_cnt cleared on entry.
  - If locked_s=0, go to PLL_RST:
    - lock_loss_cnt+1, saturating at 255;
    - sys_rst_n=0 and ready=0 in the next cycle (same edge as the transition).
- State FAULT (4):
  - pll_rst=1, sys_rst_n=0, ready=0, fault=1, retry_cnt holds its final value.
  - Exits only on soft_reset_req or rst_n.
- soft_reset_req (any state):
  - go to PLL_RST with counter=0;
  - clear retry_cnt and fault;
  - sys_rst_n=0 and ready=0 next cycle.
- Priorities:
  - soft_reset_req beats every other transition.
  - In RUN, if lock loss and soft_reset_req coincide, lock_loss_cnt still increments.
  - In WAIT_LOCK, lock seen on the timeout cycle goes to STABLE, not retry.
- Latency: ready rises exactly LOCK_STABLE_CYC+3 cycles after pll_locked rises, provided pll_locked stays high.
- Reset mid-operation: rst_n low forces the reset values immediately. lock_loss_cnt is cleared only by rst_n.
- Unused state encodings 5–7 recover to PLL_RST.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum and its 3-bit encodings;
  - the widths of retry_cnt and lock_loss_cnt;
  - the lock_loss_cnt saturation constant.
- One sub-module: bit_sync_2ff, a parameterizable-depth single-bit synchronizer with async active-low reset. It is reused elsewhere.

Test Plan:
Bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRIES=2.
- Normal bring-up: release rst_n; raise pll_locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready and sys_rst_n rise 11 cycles after pll_locked; retry_cnt=0.
- Timeout/fault: pll_locked held low -> 3 pll_rst pulses of 4 cycles each; fault=1 at cycle 72 after release; retry_cnt=2; pll_rst=1; state_o=4.
- Glitchy lock: pll_locked high 4 cycles, low 1, then high -> returns to WAIT_LOCK, no release; ready rises 11 cycles after the final rising edge.
- Lock loss in RUN: drop pll_locked for 3 cycles -> ready=0 and sys_rst_n=0 on the 3rd cycle after the drop; lock_loss_cnt=1; 4-cycle pll_rst pulse; re-lock releases again.
- Fault recovery and priority: soft_reset_req in FAULT -> fault=0, retry_cnt=0, new pll_rst pulse. soft_reset_req coincident with lock loss in RUN -> PLL_RST, lock_loss_cnt+1.
- Saturation: 260 lock-loss events -> lock_loss_cnt=255. Then assert rst_n low mid-STABLE -> all outputs return to their reset values immediately.
